sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares one SRAM wrapper port (the `io_sram_*` interface feeding `ram_wrapper`) between an instruction-fetch requester and a data requester. The block accepts one request at a time and sequences it into a fixed-length SRAM read or write cycle. It enforces write-to-read turnaround and returns one response pulse per request. It sits between the core and the BaseRAM wrapper, so the core can fetch and load/store from the same physical SRAM.

## Interface
- `ADDR_W`, 20, SRAM word-address width.
- `READ_CYCLES`, 2, cycles `sram_en`/`sram_re` are held per read (≥1).
- `WRITE_CYCLES`, 2, cycles `sram_en`/`sram_we` are held per write (≥1).
- `MAX_STREAK`, 4, maximum consecutive data grants while fetch is waiting (≥1).

Ports:
- `clk`  in  1  the only clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `i_req_valid`  in  1  fetch request.
- `i_req_ready`  out  1  fetch request accepted this cycle.
- `i_req_addr`  in  ADDR_W  fetch word address.
- `i_resp_valid`  out  1  one-cycle pulse: `i_resp_data` valid.
- `i_resp_data`  out  32  fetched word.
- `d_req_valid`  in  1  data request.
- `d_req_ready`  out  1  data request accepted this cycle.
- `d_req_addr`  in  ADDR_W  data word address.
- `d_req_we`  in  1  1 = write, 0 = read.
- `d_req_wdata`  in  32  write data.
- `d_req_wmask`  in  4  byte-write mask, 1 = write byte.
- `d_resp_valid`  out  1  one-cycle pulse: read data valid, or write done.
- `d_resp_data`  out  32  read word; 0 for write acks.
- `sram_addr`  out  ADDR_W  to wrapper.
- `sram_wdata`  out  32  to wrapper write data.
- `sram_rdata`  in  32  from wrapper read data.
- `sram_en`, `sram_re`, `sram_we`  out  1 each  wrapper strobes.
- `sram_wmask`  out  4  wrapper byte mask.

## Operation
- FSM states: IDLE, READ, WRITE, TURN.
- Ready signals are high only in IDLE, and only for the granted requester. Ready may depend combinationally on both valids. Request fields are captured on `valid && ready`.
- Grant rule in IDLE:
  - Data wins when both requesters are valid, unless `streak == MAX_STREAK`; then fetch wins.
  - A single valid requester always wins.
- `streak` counter:
  - Increments on a data grant while `i_req_valid` is 1, saturating at `MAX_STREAK`.
  - Clears on a fetch grant, or on a data grant while `i_req_valid` is 0.
  - Width is clog2(MAX_STREAK+1).
- Transitions:
  - IDLE → READ on a fetch grant or a data read grant.
  - IDLE → WRITE on a data write grant.
  - READ holds for `READ_CYCLES`, then → IDLE.
  - WRITE holds for `WRITE_CYCLES`, then → TURN.
  - TURN → IDLE after 1 cycle.
- Outputs in READ: `sram_en=1`, `sram_re=1`, `sram_we=0`, `sram_wmask=4'hF`, `sram_addr` = captured address.
- Outputs in WRITE: `sram_en=1`, `sram_we=1`, `sram_re=0`; captured wdata and wmask are driven.
- In IDLE and TURN all strobes and `sram_wmask` are 0. `sram_addr` and `sram_wdata` hold their last values.
- `sram_rdata` is registered at the clock edge ending the last READ cycle.
- A write with `d_req_wmask==0` still performs the full WRITE/TURN sequence.
- The owner tag is registered at grant and selects which resp port pulses.
- Responses cannot be back-pressured. Requesters must accept them.

## Timing
- Reset values:
  - State IDLE, `streak` 0, owner tag 0.
  - All `*_resp_valid`, `sram_en/re/we` are 0. `sram_wmask`, `sram_addr`, `sram_wdata` and `*_resp_data` are 0.
  - Ready signals are 0 while `rst_n=0`.
- Read accepted in cycle T:
  - Strobes are asserted in cycles T+1 … T+READ_CYCLES.
  - `*_resp_valid` is high with data in cycle T+READ_CYCLES+1, for exactly 1 cycle.
  - That cycle is IDLE, so a new request can be accepted in the same cycle. Back-to-back read period is READ_CYCLES+1.
- Write accepted in cycle T:
  - Strobes are asserted in cycles T+1 … T+WRITE_CYCLES.
  - The TURN cycle T+WRITE_CYCLES+1 carries `d_resp_valid`.
  - The next acceptance is at the earliest in T+WRITE_CYCLES+2, so at least one dead cycle always precedes the next SRAM cycle.
- Resp data holds until the next response of the same port.
- Asynchronous `rst_n` assertion mid-operation drops all strobes immediately. The in-flight request gets no response. The first acceptance is possible in the first cycle after deassertion.

## Test plan
- Reset: hold `rst_n=0` with both valids high → all strobes 0 and both readies 0. After release, the first fetch is accepted in the first IDLE cycle.
- Single fetch: fetch of addr 0x00010, SRAM model returns 0x12345678 (READ_CYCLES=2) → `sram_en/re` high 2 cycles at 0x00010, `i_resp_valid` 3 cycles after acceptance with 0x12345678. No `d_resp_valid` pulse occurs.
- Write then read: data write 0xDEADBEEF to 0x00100 with mask 4'b0011, then a read of 0x00100 → `we` held 2 cycles with mask 0011, ack in TURN, one strobe-free cycle, then the read returns 0x????BEEF per the model.
- Simultaneous requests: both valid in the same IDLE cycle → data granted, fetch ready 0. Fetch is granted in the next IDLE cycle if data is idle.
- Starvation bound: MAX_STREAK=4, `d_req_valid` and `i_req_valid` held high continuously → grants go D, D, D, D, I, D… and `streak` returns to 0 after the fetch grant.
- Reset mid-write: assert `rst_n=0` during the first WRITE cycle → `sram_we` falls the same cycle and no `d_resp_valid` is produced.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one SRAM wrapper port between fetch and data requesters
module sram_port_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2,
  parameter int MAX_STREAK   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [31:0]       i_resp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_we,
  input  logic [31:0]       d_req_wdata,
  input  logic [3:0]        d_req_wmask,
  output logic              d_resp_valid,
  output logic [31:0]       d_resp_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              sram_en,
  output logic              sram_re,
  output logic              sram_we,
  output logic [3:0]        sram_wmask
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);
  localparam int MAX_CYC  = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
  localparam int CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
  localparam logic [CNT_W-1:0]    READ_LAST  = CNT_W'(READ_CYCLES - 1);
  localparam logic [CNT_W-1:0]    WRITE_LAST = CNT_W'(WRITE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [STREAK_W-1:0] streak_q;
  logic                owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wmask_q;
  logic                i_resp_valid_q, d_resp_valid_q;
  logic [31:0]         i_resp_data_q, d_resp_data_q;
  logic                grant_d, grant_i;

  // Data has priority unless fetch has already waited out MAX_STREAK data grants.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state_q == IDLE) begin
      grant_d = d_req_valid && !(i_req_valid && streak_q == STREAK_MAX);
      grant_i = i_req_valid && !grant_d;
    end
  end

  assign i_req_ready  = rst_n && grant_i;
  assign d_req_ready  = rst_n && grant_d;
  assign sram_addr    = addr_q;
  assign sram_wdata   = wdata_q;
  assign i_resp_valid = i_resp_valid_q;
  assign d_resp_valid = d_resp_valid_q;
  assign i_resp_data  = i_resp_data_q;
  assign d_resp_data  = d_resp_data_q;

  always_comb begin
    state_d    = state_q;
    sram_en    = 1'b0;
    sram_re    = 1'b0;
    sram_we    = 1'b0;
    sram_wmask = 4'h0;
    case (state_q)
      IDLE: begin
        if (grant_i || (grant_d && !d_req_we)) state_d = READ;
        else if (grant_d)                      state_d = WRITE;
      end
      READ: begin
        sram_en    = 1'b1;
        sram_re    = 1'b1;
        sram_wmask = 4'hF;
        if (cnt_q == READ_LAST) state_d = IDLE;
      end
      WRITE: begin
        sram_en    = 1'b1;
        sram_we    = 1'b1;
        sram_wmask = wmask_q;
        if (cnt_q == WRITE_LAST) state_d = TURN;
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      streak_q       <= '0;
      owner_q        <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wmask_q        <= '0;
      i_resp_valid_q <= 1'b0;
      d_resp_valid_q <= 1'b0;
      i_resp_data_q  <= '0;
      d_resp_data_q  <= '0;
    end else begin
      i_resp_valid_q <= 1'b0;
      d_resp_valid_q <= 1'b0;
      cnt_q <= (state_d == state_q && (state_q == READ || state_q == WRITE)) ? cnt_q + 1'b1 : '0;

      if (grant_d) begin
        owner_q <= 1'b1;
        addr_q  <= d_req_addr;
        if (d_req_we) begin
          wdata_q <= d_req_wdata;
          wmask_q <= d_req_wmask;
        end
        if (!i_req_valid)              streak_q <= '0;
        else if (streak_q != STREAK_MAX) streak_q <= streak_q + 1'b1;
      end else if (grant_i) begin
        owner_q  <= 1'b0;
        addr_q   <= i_req_addr;
        streak_q <= '0;
      end

      // Read data is sampled on the edge that ends the last strobe cycle.
      if (state_q == READ && cnt_q == READ_LAST) begin
        if (owner_q) begin
          d_resp_valid_q <= 1'b1;
          d_resp_data_q  <= sram_rdata;
        end else begin
          i_resp_valid_q <= 1'b1;
          i_resp_data_q  <= sram_rdata;
        end
      end
      if (state_q == WRITE && cnt_q == WRITE_LAST) begin
        d_resp_valid_q <= 1'b1;
        d_resp_data_q  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed and randomized checks of sram_port_arbiter against a transaction model
module tb_sram_port_arbiter;
  localparam int ADDR_W = 20;
  localparam int RC     = 2;
  localparam int WC     = 2;
  localparam int MS     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_req_valid = 1'b0, d_req_valid = 1'b0, d_req_we = 1'b0;
  logic [ADDR_W-1:0] i_req_addr = '0, d_req_addr = '0;
  logic [31:0]       d_req_wdata = '0;
  logic [3:0]        d_req_wmask = '0;
  logic              i_req_ready, d_req_ready, i_resp_valid, d_resp_valid;
  logic [31:0]       i_resp_data, d_resp_data, sram_wdata, sram_rdata;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_en, sram_re, sram_we;
  logic [3:0]        sram_wmask;

  logic [31:0] sram_mem [0:1023];
  logic [31:0] shadow   [0:1023];
  assign sram_rdata = sram_mem[sram_addr[9:0]];

  sram_port_arbiter #(.ADDR_W(ADDR_W), .READ_CYCLES(RC), .WRITE_CYCLES(WC), .MAX_STREAK(MS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_en(sram_en), .sram_re(sram_re), .sram_we(sram_we), .sram_wmask(sram_wmask)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  int busy_until = -1, st_from = 0, st_to = -1, resp_cyc = -1, streak_m = 0;
  logic              st_we = 1'b0, resp_port = 1'b0;
  logic [ADDR_W-1:0] st_addr = '0;
  logic [31:0]       st_wdata = '0, resp_val = '0, exp_i_data = '0, exp_d_data = '0;
  logic [3:0]        st_mask = '0;
  bit                hold_valids = 1'b0;
  int                acc_i = -1, acc_d = -1, last_i_resp = -1, d_resp_count = 0;
  logic [31:0]       last_i_data = '0, last_d_data = '0;
  string             gstr = "";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    busy_until = -1; st_from = 0; st_to = -1; resp_cyc = -1; streak_m = 0;
    exp_i_data = '0; exp_d_data = '0;
  endtask

  // One clock: check mid-cycle outputs against the model, then advance the model on acceptance.
  task automatic cycle_check();
    logic egi, egd, act;
    egi = 1'b0; egd = 1'b0;
    @(negedge clk);
    if (!rst_n) begin
      model_reset();
      chk("rst_ready", 32'({i_req_ready, d_req_ready}), 32'd0);
      chk("rst_strobes", 32'({sram_en, sram_re, sram_we, sram_wmask}), 32'd0);
      chk("rst_resp_valid", 32'({i_resp_valid, d_resp_valid}), 32'd0);
      chk("rst_i_resp_data", i_resp_data, 32'd0);
      chk("rst_d_resp_data", d_resp_data, 32'd0);
    end else begin
      egd = (cyc > busy_until) && d_req_valid && !(i_req_valid && streak_m == MS);
      egi = (cyc > busy_until) && i_req_valid && !egd;
      chk("i_ready", 32'(i_req_ready), 32'(egi));
      chk("d_ready", 32'(d_req_ready), 32'(egd));
      act = (cyc >= st_from) && (cyc <= st_to);
      chk("sram_en", 32'(sram_en), 32'(act));
      chk("sram_re", 32'(sram_re), 32'(act && !st_we));
      chk("sram_we", 32'(sram_we), 32'(act && st_we));
      chk("sram_wmask", 32'(sram_wmask), 32'(act ? (st_we ? st_mask : 4'hF) : 4'h0));
      if (act) chk("sram_addr", 32'(sram_addr), 32'(st_addr));
      if (act && st_we) chk("sram_wdata", sram_wdata, st_wdata);
      if (resp_cyc == cyc) begin
        if (resp_port) exp_d_data = resp_val;
        else           exp_i_data = resp_val;
      end
      chk("i_resp_valid", 32'(i_resp_valid), 32'(resp_cyc == cyc && !resp_port));
      chk("d_resp_valid", 32'(d_resp_valid), 32'(resp_cyc == cyc && resp_port));
      chk("i_resp_data", i_resp_data, exp_i_data);
      chk("d_resp_data", d_resp_data, exp_d_data);
      if (i_resp_valid) begin last_i_resp = cyc; last_i_data = i_resp_data; end
      if (d_resp_valid) begin d_resp_count++; last_d_data = d_resp_data; end
      if (i_req_ready && i_req_valid)      gstr = {gstr, "I"};
      else if (d_req_ready && d_req_valid) gstr = {gstr, "D"};
      if (sram_en && sram_we)
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) sram_mem[sram_addr[9:0]][8*b +: 8] = sram_wdata[8*b +: 8];
      if (egd || egi) begin
        if (egd) streak_m = i_req_valid ? ((streak_m < MS) ? streak_m + 1 : MS) : 0;
        else     streak_m = 0;
        st_from   = cyc + 1;
        st_we     = egd && d_req_we;
        st_addr   = egd ? d_req_addr : i_req_addr;
        st_wdata  = d_req_wdata;
        st_mask   = d_req_wmask;
        resp_port = egd;
        if (st_we) begin
          st_to = cyc + WC; busy_until = cyc + WC + 1; resp_cyc = cyc + WC + 1; resp_val = '0;
          shadow[st_addr[9:0]] = merge(shadow[st_addr[9:0]], st_wdata, st_mask);
        end else begin
          st_to = cyc + RC; busy_until = cyc + RC; resp_cyc = cyc + RC + 1;
          resp_val = shadow[st_addr[9:0]];
        end
        if (egd) acc_d = cyc; else acc_i = cyc;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (egi && !hold_valids) i_req_valid = 1'b0;
    if (egd && !hold_valids) d_req_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle_check();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, w, a_i0, c0, n0;
    for (int k = 0; k < 1024; k++) begin
      sram_mem[k] = $urandom;
      shadow[k]   = sram_mem[k];
    end
    sram_mem[16]  = 32'h12345678; shadow[16]  = 32'h12345678;
    sram_mem[256] = 32'hA5A5A5A5; shadow[256] = 32'hA5A5A5A5;

    // Reset with both requesters valid, then a lone fetch right after release.
    i_req_valid = 1'b1; i_req_addr = ADDR_W'(16);
    d_req_valid = 1'b1; d_req_addr = ADDR_W'(5);
    #2;
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_wdata", sram_wdata, 32'd0);
    idle_cycles(3);
    rst_n = 1'b1; d_req_valid = 1'b0;
    rel = cyc;
    idle_cycles(5);
    chk("first_fetch_accept", 32'(acc_i), 32'(rel));
    chk("fetch_resp_cycle", 32'(last_i_resp), 32'(acc_i + RC + 1));
    chk("fetch_resp_data", last_i_data, 32'h12345678);
    chk("fetch_no_d_resp", 32'(d_resp_count), 32'd0);

    // Masked write followed immediately by a read of the same word.
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = ADDR_W'(256);
    d_req_wdata = 32'hDEADBEEF; d_req_wmask = 4'b0011;
    w = acc_d;
    for (int k = 0; k < 20 && acc_d == w; k++) cycle_check();
    w = acc_d;
    d_req_valid = 1'b1; d_req_we = 1'b0;
    for (int k = 0; k < 20 && acc_d == w; k++) cycle_check();
    chk("wr_rd_gap", 32'(acc_d), 32'(w + WC + 2));
    idle_cycles(RC + 2);
    chk("wr_rd_data", last_d_data, 32'hA5A5BEEF);

    // Simultaneous requests: data first, fetch at the next IDLE.
    i_req_valid = 1'b1; i_req_addr = ADDR_W'(7);
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = ADDR_W'(9);
    a_i0 = acc_i; c0 = cyc;
    cycle_check();
    chk("simul_data_first", 32'(acc_d), 32'(c0));
    for (int k = 0; k < 20 && acc_i == a_i0; k++) cycle_check();
    chk("simul_fetch_next", 32'(acc_i), 32'(c0 + RC + 1));
    idle_cycles(5);

    // Starvation bound with both requesters held valid.
    gstr = "";
    hold_valids = 1'b1;
    i_req_valid = 1'b1; d_req_valid = 1'b1; d_req_we = 1'b0;
    for (int k = 0; k < 200 && gstr.len() < 10; k++) cycle_check();
    hold_valids = 1'b0; i_req_valid = 1'b0; d_req_valid = 1'b0;
    checks++;
    assert (gstr.substr(0, 9) == "DDDDIDDDDI") else begin
      failures++;
      $error("FAIL starvation_order observed=%s expected=DDDDIDDDDI", gstr);
    end
    idle_cycles(5);

    // Reset during the first WRITE cycle: strobes drop at once, no ack.
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = ADDR_W'(64);
    d_req_wdata = shadow[64]; d_req_wmask = 4'hF;
    w = acc_d;
    for (int k = 0; k < 20 && acc_d == w; k++) cycle_check();
    chk("midwrite_we_before", 32'(sram_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midwrite_we_drop", 32'(sram_we), 32'd0);
    chk("midwrite_en_drop", 32'(sram_en), 32'd0);
    n0 = d_resp_count;
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(6);
    chk("midwrite_no_ack", 32'(d_resp_count), 32'(n0));

    // Randomized traffic over a small address window.
    for (int k = 0; k < 500; k++) begin
      cycle_check();
      if (!i_req_valid && $urandom_range(0, 2) == 0) begin
        i_req_valid = 1'b1;
        i_req_addr  = ADDR_W'($urandom_range(0, 31));
      end
      if (!d_req_valid && $urandom_range(0, 1) == 0) begin
        d_req_valid = 1'b1;
        d_req_we    = 1'($urandom_range(0, 1));
        d_req_addr  = ADDR_W'($urandom_range(0, 31));
        d_req_wdata = $urandom;
        d_req_wmask = 4'($urandom_range(0, 15));
      end
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    idle_cycles(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
